// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue-stage definitions: alu_op classes, R-type funct codes,
// operation-select encodings and the decoded control bundle.
package alu_issue_stage_pkg;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_SLTI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    OPER_AND = 3'b000,
    OPER_OR  = 3'b001,
    OPER_ADD = 3'b010,
    OPER_SLT = 3'b011
  } oper_e;

  typedef struct packed {
    oper_e oper;
    logic  invert;
    logic  carry;
    logic  illegal;
  } ctrl_t;

  // SUB and SLT both need B inverted with carry-in set to form A - B.
  function automatic ctrl_t make_ctrl(oper_e oper, logic sub);
    ctrl_t c;
    c.oper    = oper;
    c.invert  = sub;
    c.carry   = sub;
    c.illegal = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into ALU operation, B-invert and carry-in.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = make_ctrl(OPER_ADD, 1'b0);
    case (alu_op)
      ALUOP_LDST:   ctrl = make_ctrl(OPER_ADD, 1'b0);
      ALUOP_BRANCH: ctrl = make_ctrl(OPER_ADD, 1'b1);
      ALUOP_SLTI:   ctrl = make_ctrl(OPER_SLT, 1'b1);
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = make_ctrl(OPER_ADD, 1'b0);
          FUNCT_SUB: ctrl = make_ctrl(OPER_ADD, 1'b1);
          FUNCT_AND: ctrl = make_ctrl(OPER_AND, 1'b0);
          FUNCT_OR:  ctrl = make_ctrl(OPER_OR,  1'b0);
          FUNCT_SLT: ctrl = make_ctrl(OPER_SLT, 1'b1);
          default:   ctrl.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes on acceptance and holds entries in a 2-deep skid
// buffer whose main entry drives the ALU inputs directly.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          up_valid_i,
  output logic          up_ready_o,
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  b_i,
  input  logic [1:0]    alu_op_i,
  input  logic [5:0]    funct_i,
  input  logic [RW-1:0] rd_i,
  output logic          down_valid_o,
  input  logic          down_ready_i,
  output logic [N-1:0]  a_o,
  output logic [N-1:0]  b_o,
  output logic [RW-1:0] rd_o,
  output logic [2:0]    operacion_o,
  output logic          invert_o,
  output logic          carry_o,
  output logic          illegal_o
);

  ctrl_t         in_ctrl;
  logic          main_valid, skid_valid, ready_q;
  logic [N-1:0]  main_a, main_b, skid_a, skid_b;
  logic [RW-1:0] main_rd, skid_rd;
  ctrl_t         main_ctrl, skid_ctrl;
  logic          take_in, take_out;

  alu_ctrl_decode u_decode (
    .alu_op (alu_op_i),
    .funct  (funct_i),
    .ctrl   (in_ctrl)
  );

  assign take_in  = up_valid_i && ready_q;
  assign take_out = main_valid && down_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_a     <= '0;
      main_b     <= '0;
      main_rd    <= '0;
      main_ctrl  <= make_ctrl(OPER_ADD, 1'b0);
      skid_a     <= '0;
      skid_b     <= '0;
      skid_rd    <= '0;
      skid_ctrl  <= make_ctrl(OPER_ADD, 1'b0);
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (!main_valid || take_out) begin
      // Main is free this cycle: refill from skid first to keep order, else from input.
      if (skid_valid) begin
        main_a     <= skid_a;
        main_b     <= skid_b;
        main_rd    <= skid_rd;
        main_ctrl  <= skid_ctrl;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (take_in) begin
        main_a     <= a_i;
        main_b     <= b_i;
        main_rd    <= rd_i;
        main_ctrl  <= in_ctrl;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take_in) begin
      skid_a     <= a_i;
      skid_b     <= b_i;
      skid_rd    <= rd_i;
      skid_ctrl  <= in_ctrl;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

  assign up_ready_o   = ready_q;
  assign down_valid_o = main_valid;
  assign a_o          = main_a;
  assign b_o          = main_b;
  assign rd_o         = main_rd;
  assign operacion_o  = main_ctrl.oper;
  assign invert_o     = main_ctrl.invert;
  assign carry_o      = main_ctrl.carry;
  assign illegal_o    = main_ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomised self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, up_ready, down_valid, down_ready;
  logic [31:0] a_in, b_in, a_out, b_out;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  rd_in, rd_out;
  logic [2:0]  operacion;
  logic        invert, carry, illegal;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(32), .RW(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .up_valid_i   (up_valid),
    .up_ready_o   (up_ready),
    .a_i          (a_in),
    .b_i          (b_in),
    .alu_op_i     (alu_op),
    .funct_i      (funct),
    .rd_i         (rd_in),
    .down_valid_o (down_valid),
    .down_ready_i (down_ready),
    .a_o          (a_out),
    .b_o          (b_out),
    .rd_o         (rd_out),
    .operacion_o  (operacion),
    .invert_o     (invert),
    .carry_o      (carry),
    .illegal_o    (illegal)
  );

  // {operacion, invert, carry, illegal} expected for a given class/funct
  function automatic logic [5:0] exp_ctrl(logic [1:0] op, logic [5:0] f);
    case (op)
      2'b00: return 6'b010_0_0_0;
      2'b01: return 6'b010_1_1_0;
      2'b11: return 6'b011_1_1_0;
      default:
        case (f)
          6'b100000: return 6'b010_0_0_0;
          6'b100010: return 6'b010_1_1_0;
          6'b100100: return 6'b000_0_0_0;
          6'b100101: return 6'b001_0_0_0;
          6'b101010: return 6'b011_1_1_0;
          default:   return 6'b010_0_0_1;
        endcase
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [5:0] f,
                       logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    up_valid = v; alu_op = op; funct = f; a_in = a; b_in = b; rd_in = rd;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; down_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100010, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
    step; step;
    rst = 1'b0; up_valid = 1'b0;
    compared++;
    if ({down_valid, up_ready, a_out, b_out, rd_out, operacion, invert, carry, illegal}
        !== {1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b r=%b a=%h b=%h rd=%0d op=%b inv=%b c=%b ill=%b want v=0 r=1 zeros op=010",
               down_valid, up_ready, a_out, b_out, rd_out, operacion, invert, carry, illegal);
    end
  endtask

  task automatic test_sub;
    down_ready = 1'b1;
    drive(1'b1, 2'b10, 6'b100010, 32'd7, 32'd3, 5'd5);
    step;
    up_valid = 1'b0;
    compared++;
    if ({down_valid, operacion, invert, carry, illegal, a_out, b_out, rd_out}
        !== {1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 32'd7, 32'd3, 5'd5}) begin
      mismatched++;
      $display("FAIL sub_latency1: got v=%b op=%b inv=%b c=%b ill=%b a=%0d b=%0d rd=%0d want 1 010 1 1 0 7 3 5",
               down_valid, operacion, invert, carry, illegal, a_out, b_out, rd_out);
    end
    step;
    compared++;
    if (down_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_drain: got valid=%b want 0", down_valid);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [5:0] exp;
  } dec_vec_t;

  task automatic test_decode;
    dec_vec_t v[10] = '{
      '{2'b00, 6'b111111, 6'b010_0_0_0},
      '{2'b01, 6'b000000, 6'b010_1_1_0},
      '{2'b11, 6'b100100, 6'b011_1_1_0},
      '{2'b10, 6'b100000, 6'b010_0_0_0},
      '{2'b10, 6'b100010, 6'b010_1_1_0},
      '{2'b10, 6'b100100, 6'b000_0_0_0},
      '{2'b10, 6'b100101, 6'b001_0_0_0},
      '{2'b10, 6'b101010, 6'b011_1_1_0},
      '{2'b10, 6'b000000, 6'b010_0_0_1},
      '{2'b10, 6'b101011, 6'b010_0_0_1}
    };
    down_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, v[i].op, v[i].f, 32'(i + 100), 32'(i + 200), 5'(i));
      step;
      up_valid = 1'b0;
      compared++;
      if ({down_valid, operacion, invert, carry, illegal, a_out, rd_out}
          !== {1'b1, v[i].exp, 32'(i + 100), 5'(i)}) begin
        mismatched++;
        $display("FAIL decode[%0d]: got v=%b ctrl=%b a=%0d rd=%0d want v=1 ctrl=%b a=%0d rd=%0d",
                 i, down_valid, {operacion, invert, carry, illegal}, a_out, rd_out,
                 v[i].exp, i + 100, i);
      end
      step;
    end
  endtask

  task automatic test_back_to_back_stall;
    down_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100000, 32'd1, 32'd11, 5'd1);
    step;
    compared++;
    if ({up_ready, down_valid, a_out, b_out} !== {1'b1, 1'b1, 32'd1, 32'd11}) begin
      mismatched++;
      $display("FAIL stall_c1: got r=%b v=%b a=%0d b=%0d want 1 1 1 11", up_ready, down_valid, a_out, b_out);
    end
    drive(1'b1, 2'b10, 6'b100000, 32'd2, 32'd12, 5'd2);
    step;
    compared++;
    if ({up_ready, down_valid, a_out} !== {1'b0, 1'b1, 32'd1}) begin
      mismatched++;
      $display("FAIL stall_c2: got r=%b v=%b a=%0d want 0 1 1", up_ready, down_valid, a_out);
    end
    drive(1'b1, 2'b10, 6'b100000, 32'd3, 32'd13, 5'd3);
    step;
    compared++;
    if ({up_ready, down_valid, a_out} !== {1'b0, 1'b1, 32'd1}) begin
      mismatched++;
      $display("FAIL stall_c3_hold: got r=%b v=%b a=%0d want 0 1 1", up_ready, down_valid, a_out);
    end
    down_ready = 1'b1;
    step;
    compared++;
    if ({up_ready, down_valid, a_out, b_out} !== {1'b1, 1'b1, 32'd2, 32'd12}) begin
      mismatched++;
      $display("FAIL release_2nd: got r=%b v=%b a=%0d b=%0d want 1 1 2 12", up_ready, down_valid, a_out, b_out);
    end
    step;
    up_valid = 1'b0;
    compared++;
    if ({down_valid, a_out, b_out, rd_out} !== {1'b1, 32'd3, 32'd13, 5'd3}) begin
      mismatched++;
      $display("FAIL release_3rd: got v=%b a=%0d b=%0d rd=%0d want 1 3 13 3", down_valid, a_out, b_out, rd_out);
    end
    step;
    compared++;
    if (down_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL release_empty: got valid=%b want 0", down_valid);
    end
  endtask

  task automatic test_flush;
    down_ready = 1'b0;
    drive(1'b1, 2'b00, 6'b0, 32'd21, 32'd0, 5'd1);
    step;
    drive(1'b1, 2'b00, 6'b0, 32'd22, 32'd0, 5'd2);
    step;
    drive(1'b1, 2'b00, 6'b0, 32'd23, 32'd0, 5'd3);
    flush = 1'b1;
    step;
    flush = 1'b0; up_valid = 1'b0;
    compared++;
    if ({down_valid, up_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL flush_full: got v=%b r=%b want v=0 r=1", down_valid, up_ready);
    end
    drive(1'b1, 2'b00, 6'b0, 32'd24, 32'd0, 5'd4);
    flush = 1'b1;
    step;
    flush = 1'b0; up_valid = 1'b0;
    compared++;
    if ({down_valid, up_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL flush_over_accept: got v=%b r=%b want v=0 r=1", down_valid, up_ready);
    end
    down_ready = 1'b1;
    step;
    compared++;
    if (down_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_no_emit: got valid=%b want 0", down_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    down_ready = 1'b0;
    drive(1'b1, 2'b11, 6'b0, 32'd31, 32'd41, 5'd7);
    step;
    drive(1'b1, 2'b11, 6'b0, 32'd32, 32'd42, 5'd8);
    step;
    rst = 1'b1; flush = 1'b1;
    step;
    rst = 1'b0; flush = 1'b0; up_valid = 1'b0; down_ready = 1'b1;
    compared++;
    if ({down_valid, up_ready, a_out, rd_out, operacion, invert}
        !== {1'b0, 1'b1, 32'd0, 5'd0, 3'b010, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_stall: got v=%b r=%b a=%0d rd=%0d op=%b inv=%b want 0 1 0 0 010 0",
               down_valid, up_ready, a_out, rd_out, operacion, invert);
    end
    step;
    compared++;
    if (down_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_emit: got valid=%b want 0", down_valid);
    end
  endtask

  task automatic test_random;
    logic [74:0] q[$];
    logic [74:0] obs, prev_obs;
    logic        prev_stall = 1'b0;
    logic        exp_rdy, exp_vld, acc, outb;
    int          sent = 0, recv = 0, cycles = 0, local_fail = 0;
    up_valid = 1'b0; down_ready = 1'b0;
    while (recv < 10000 && cycles < 80000 && local_fail < 10) begin
      obs     = {a_out, b_out, rd_out, operacion, invert, carry, illegal};
      exp_rdy = (q.size() < 2);
      exp_vld = (q.size() > 0);
      compared++;
      if ({up_ready, down_valid} !== {exp_rdy, exp_vld}) begin
        mismatched++; local_fail++;
        $display("FAIL rand_handshake cyc=%0d: got r=%b v=%b want r=%b v=%b",
                 cycles, up_ready, down_valid, exp_rdy, exp_vld);
      end
      if (prev_stall) begin
        compared++;
        if (obs !== prev_obs) begin
          mismatched++; local_fail++;
          $display("FAIL rand_stable cyc=%0d: got %h want %h", cycles, obs, prev_obs);
        end
      end
      acc  = up_valid && exp_rdy;
      outb = exp_vld && down_ready;
      if (outb) begin
        compared++;
        if (obs !== q[0]) begin
          mismatched++; local_fail++;
          $display("FAIL rand_order cyc=%0d entry=%0d: got %h want %h", cycles, recv, obs, q[0]);
        end
        void'(q.pop_front());
        recv++;
      end
      if (acc) begin
        q.push_back({a_in, b_in, rd_in, exp_ctrl(alu_op, funct)});
        sent++;
      end
      prev_stall = exp_vld && !down_ready;
      prev_obs   = obs;
      step;
      cycles++;
      drive((sent < 10000) && ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) funct = 6'b100100;
      down_ready = ($urandom_range(0, 2) != 0);
    end
    up_valid = 1'b0;
    compared++;
    if (recv != 10000 || q.size() != 0) begin
      mismatched++;
      $display("FAIL rand_complete: got received=%0d pending=%0d after %0d cycles want 10000 0",
               recv, q.size(), cycles);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; down_ready = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'd0, 32'd0, 5'd0);
    test_reset;
    test_sub;
    test_decode;
    test_back_to_back_stall;
    test_flush;
    test_reset_mid_stall;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter N, default 32, giving operand width.
REQ-002 The block SHALL have parameter RW, default 5, giving destination-register tag width.
REQ-003 Port clk_i  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port flush_i  input  1  synchronous discard of all held entries.
REQ-006 Port up_valid_i  input  1  upstream entry present.
REQ-007 Port up_ready_o  output  1  stage can accept an entry.
REQ-008 Port a_i, b_i  input  N each  source operands.
REQ-009 Port alu_op_i  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 set-less-immediate.
REQ-010 Port funct_i  input  6  R-type function field.
REQ-011 Port rd_i  input  RW  destination tag.
REQ-012 Port down_valid_o  output  1  entry presented to the ALU.
REQ-013 Port down_ready_i  input  1  ALU side consumes the presented entry.
REQ-014 Ports a_o, b_o (N), rd_o (RW)  output  registered copies of accepted data.
REQ-015 Ports operacion_o (3), invert_o (1), carry_o (1)  output  ALU controls: operation select, B-invert, carry-in.
REQ-016 Port illegal_o  output  1  presented entry had an undecodable funct.

Function
REQ-017 Decode SHALL occur at acceptance; the registered controls SHALL be: AND -> 000/0/0, OR -> 001/0/0, ADD -> 010/0/0, SUB -> 010/1/1, SLT -> 011/1/1 (operacion/invert/carry).
REQ-018 alu_op 00 SHALL decode to ADD, 01 to SUB, 11 to SLT, ignoring funct_i.
REQ-019 alu_op 10 SHALL decode funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct SHALL decode to ADD with illegal set.
REQ-020 Transfer in occurs when up_valid_i && up_ready_o; transfer out when down_valid_o && down_ready_i.
REQ-021 Storage SHALL be a 2-entry skid buffer: main entry (drives outputs) and skid entry.
REQ-022 up_ready_o SHALL be a registered signal equal to NOT skid-valid; it SHALL not depend combinationally on down_ready_i.
REQ-023 Empty + accept: entry SHALL appear on outputs with down_valid_o=1 the next cycle (latency 1).
REQ-024 Main valid + simultaneous transfer in and out: incoming entry SHALL replace main; throughput 1 per cycle.
REQ-025 Main valid, no transfer out, transfer in: incoming entry SHALL go to skid; up_ready_o SHALL drop next cycle.
REQ-026 Skid valid + transfer out: skid SHALL move to main and skid SHALL empty; up_ready_o SHALL rise next cycle.
REQ-027 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-028 Output data/controls SHALL hold stable while down_valid_o=1 and down_ready_i=0.
REQ-029 flush_i SHALL clear both valids next cycle and SHALL override a simultaneous acceptance (entry discarded); up_ready_o SHALL be 1 after flush.
REQ-030 When down_valid_o=0, data outputs are don't-care but SHALL not be X after reset.

Reset
REQ-031 rst_i SHALL have priority over flush_i and all transfers.
REQ-032 Reset SHALL give down_valid_o=0, up_ready_o=1, skid empty, a_o=b_o=0, rd_o=0, operacion_o=010, invert_o=0, carry_o=0, illegal_o=0.
REQ-033 Reset asserted mid-stall SHALL discard both entries.

Structure
REQ-034 A shared package SHALL hold alu_op class codes, funct constants, and the operacion encodings (AND/OR/ADD/SLT).
REQ-035 Decode SHALL be one combinational sub-module, alu_ctrl_decode, instantiated once on the input side.
REQ-036 Outputs SHALL connect directly to the ALU's a_i, b_i, operacion_i, invert_i, c_i with no added logic.

Verification
REQ-037 Reset, then alu_op=10 funct=100010 a=7 b=3, down_ready=1 -> next cycle valid, operacion 010, invert 1, carry 1, a_o=7, b_o=3.
REQ-038 down_ready=0, push 3 entries on consecutive cycles -> first two held, up_ready_o=0 from cycle 3, third not accepted; release -> order 1,2 then 3.
REQ-039 alu_op=10 funct=000000 -> illegal_o=1, controls ADD.
REQ-040 Stalled with 2 entries, flush_i=1 with up_valid_i=1 -> next cycle down_valid_o=0, up_ready_o=1, no entry emitted.
REQ-041 Random valid/ready for 10000 entries versus scoreboard -> zero loss, duplication, or reordering; outputs stable under stall.
